// File: rtl/counter_ctrl_pkg.sv
// Shared opcodes and FSM state encodings for the counter controller.
package counter_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam state_t S_IDLE = 2'b00;
    localparam state_t S_RUN  = 2'b01;
    localparam state_t S_HOLD = 2'b10;
    localparam state_t S_DONE = 2'b11;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable generator: one-cycle tick every div+1 enabled cycles.
module tick_prescaler #(
    parameter int unsigned N = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] div,
    output logic         tick
);

    logic [N-1:0] pres_q, pres_d;
    logic         tick_q, tick_d;

    // Count only while enabled; a clear restarts the period without a tick.
    always_comb begin
        pres_d = pres_q;
        tick_d = 1'b0;
        if (clr) begin
            pres_d = '0;
        end else if (en) begin
            if (pres_q == div) begin
                pres_d = '0;
                tick_d = 1'b1;
            end else begin
                pres_d = pres_q + N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pres_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pres_q <= pres_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven controller sequencing a prescaled up-counter (free-run or to a limit).
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned N = 20,
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_arg,
    input  logic [N-1:0] cmd_div,
    output logic [W-1:0] data,
    output logic         busy,
    output logic         tick,
    output logic         done,
    output logic         wrap
);

    state_t       state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] limit_q, limit_d;
    logic [N-1:0] div_q, div_d;
    logic         done_q, done_d;
    logic         wrap_q, wrap_d;
    logic         busy_q;
    logic [W-1:0] data_inc;
    logic         cmd_acc;
    logic         start_acc;
    logic         starve;
    logic         pres_en;

    assign cmd_ready = !(state_q == S_RUN && tick);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign start_acc = cmd_acc && (cmd_op == OP_START);
    assign data_inc  = data_q + W'(1);

    // At div=0 a tick would fire every cycle and starve the command port; skip one tick instead.
    assign starve  = tick && cmd_valid && (div_q == '0);
    assign pres_en = (state_q == S_RUN) && (state_d == S_RUN) && !starve;

    tick_prescaler #(.N(N)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pres_en),
        .clr  (start_acc),
        .div  (div_q),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        limit_d = limit_q;
        div_d   = div_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        if (state_q == S_RUN && tick) begin
            data_d = data_inc;
            wrap_d = &data_q;
            if (limit_q != '0 && data_inc == limit_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end

        // Commands never coincide with a tick because cmd_ready is low on tick cycles.
        if (cmd_acc) begin
            case (cmd_op)
                OP_START: begin
                    state_d = S_RUN;
                    limit_d = cmd_arg;
                    div_d   = cmd_div;
                    if (cmd_arg != '0 && data_q >= cmd_arg) begin
                        data_d = '0;
                    end
                end
                OP_STOP: begin
                    case (state_q)
                        S_RUN:          state_d = S_HOLD;
                        S_HOLD, S_DONE: state_d = S_IDLE;
                        default:        state_d = state_q;
                    endcase
                end
                OP_LOAD:  data_d = cmd_arg;
                default:  data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            limit_q <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            limit_q <= limit_d;
            div_q   <= div_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            busy_q  <= (state_d == S_RUN);
        end
    end

    assign data = data_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus randomized traffic vs a cycle model.
module tb_counter_ctrl;

    localparam int unsigned N = 20;
    localparam int unsigned W = 9;
    localparam int MAXV = (1 << W) - 1;

    localparam int C_START = 0;
    localparam int C_STOP  = 1;
    localparam int C_LOAD  = 2;
    localparam int C_CLEAR = 3;

    localparam int M_IDLE = 10;
    localparam int M_RUN  = 11;
    localparam int M_HOLD = 12;
    localparam int M_DONE = 13;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic [N-1:0] cmd_div;
    logic [W-1:0] data;
    logic         busy, tick, done, wrap;

    always #5 clk = ~clk;

    counter_ctrl #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_div   (cmd_div),
        .data      (data),
        .busy      (busy),
        .tick      (tick),
        .done      (done),
        .wrap      (wrap)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode, value, and a countdown of edges until the next tick pulse.
    int m_st = M_IDLE;
    int m_data = 0, m_limit = 0, m_div = 0, m_cd = 0;
    bit m_tick = 0, m_done = 0, m_wrap = 0;

    function automatic bit m_ready();
        return !(m_st == M_RUN && m_tick);
    endfunction

    function automatic logic [W+4:0] exp_vec();
        return {W'(m_data), (m_st == M_RUN), m_tick, m_done, m_wrap, m_ready()};
    endfunction

    task automatic model_edge(input bit r, input bit v, input int op, input int arg, input int dv);
        int n_st, n_data;
        bit n_tick, n_done, n_wrap, acc, restart;
        if (r) begin
            m_st = M_IDLE; m_data = 0; m_limit = 0; m_div = 0; m_cd = 0;
            m_tick = 0; m_done = 0; m_wrap = 0;
            return;
        end
        acc = v && m_ready();
        n_st = m_st; n_data = m_data; n_tick = 0; n_done = 0; n_wrap = 0; restart = 0;
        if (m_st == M_RUN && m_tick) begin
            n_data = (m_data + 1) % (MAXV + 1);
            n_wrap = (m_data == MAXV);
            if (m_limit != 0 && m_data + 1 == m_limit) begin
                n_st = M_DONE;
                n_done = 1;
            end
        end
        if (acc) begin
            case (op)
                C_START: begin
                    n_st = M_RUN; m_limit = arg; m_div = dv; restart = 1;
                    if (arg != 0 && m_data >= arg) n_data = 0;
                end
                C_STOP: begin
                    if (m_st == M_RUN) n_st = M_HOLD;
                    else if (m_st == M_HOLD || m_st == M_DONE) n_st = M_IDLE;
                end
                C_LOAD:  n_data = arg;
                default: n_data = 0;
            endcase
        end
        if (restart) begin
            m_cd = dv + 1;
        end else if (m_st == M_RUN && n_st == M_RUN) begin
            if (!(m_tick && v && m_div == 0)) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) begin
                    n_tick = 1;
                    m_cd = m_div + 1;
                end
            end
        end
        m_st = n_st; m_data = n_data; m_tick = n_tick; m_done = n_done; m_wrap = n_wrap;
    endtask

    // One clock: drive inputs, advance the model, then sample just after the edge.
    task automatic cyc(input bit r, input bit v, input int op, input int arg, input int dv);
        rst = r; cmd_valid = v; cmd_op = 2'(op); cmd_arg = W'(arg); cmd_div = N'(dv);
        model_edge(r, v, op, arg, dv);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic send(input int op, input int arg, input int dv);
        bit ok;
        ok = 0;
        for (int k = 0; k < 4 && !ok; k++) begin
            ok = cmd_ready;
            cyc(0, 1, op, arg, dv);
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: op %0d not accepted, cmd_ready=%0b required 1", op, cmd_ready);
        end
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        rst = 1'b0;
        n_tests++; if (data !== '0)      begin n_fail++; $display("FAIL reset_data: got %0d want 0", data); end
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++; if (tick !== 1'b0)    begin n_fail++; $display("FAIL reset_tick: got %0b want 0", tick); end
        n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_tests++; if (wrap !== 1'b0)    begin n_fail++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_free_run();
        int ticks[$];
        bit seen;
        send(C_START, 0, 3);
        for (int j = 1; j <= 13; j++) begin
            idle();
            if (tick === 1'b1) ticks.push_back(j);
            n_tests++;
            if ({data, busy, tick, done, wrap, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL free_run_model cyc %0d: got %h want %h", j, {data, busy, tick, done, wrap, cmd_ready}, exp_vec());
            end
        end
        n_tests++;
        if (ticks.size() != 3 || ticks[0] != 4 || ticks[1] != 8 || ticks[2] != 12) begin
            n_fail++;
            $display("FAIL free_run_period: got %0d ticks, want ticks at cycles 4,8,12", ticks.size());
        end
        n_tests++; if (data !== W'(3)) begin n_fail++; $display("FAIL free_run_count: got %0d want 3", data); end
        send(C_LOAD, MAXV, 0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            idle();
            seen = (wrap === 1'b1);
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL wrap_timeout: wrap=%0b want 1", wrap); end
        n_tests++; if (data !== '0) begin n_fail++; $display("FAIL wrap_data: got %0d want 0", data); end
        idle();
        n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse: got %0b want 0", wrap); end
    endtask

    task automatic test_limit();
        int nt;
        bit seen;
        send(C_CLEAR, 0, 0);
        send(C_START, 5, 0);
        nt = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            idle();
            if (tick === 1'b1) nt++;
            seen = (done === 1'b1);
        end
        n_tests++; if (!seen)        begin n_fail++; $display("FAIL limit_done: done=%0b want 1", done); end
        n_tests++; if (nt != 5)      begin n_fail++; $display("FAIL limit_ticks: got %0d want 5", nt); end
        n_tests++; if (data !== W'(5)) begin n_fail++; $display("FAIL limit_data: got %0d want 5", data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL limit_busy: got %0b want 0", busy); end
        for (int k = 0; k < 10; k++) begin
            idle();
            n_tests++;
            if (data !== W'(5) || done !== 1'b0 || tick !== 1'b0) begin
                n_fail++;
                $display("FAIL limit_hold cyc %0d: data=%0d done=%0b tick=%0b want 5/0/0", k, data, done, tick);
            end
        end
    endtask

    task automatic test_pause();
        bit seen;
        int first_tick;
        send(C_CLEAR, 0, 0);
        send(C_START, 0, 2);
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            idle();
            seen = (data === W'(3));
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL pause_reach: data=%0d want 3", data); end
        send(C_STOP, 0, 0);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pause_busy: got %0b want 0", busy); end
        for (int k = 0; k < 20; k++) begin
            idle();
            n_tests++;
            if (data !== W'(3) || tick !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold cyc %0d: data=%0d tick=%0b want 3/0", k, data, tick);
            end
        end
        send(C_START, 0, 2);
        first_tick = -1;
        for (int j = 1; j <= 4; j++) begin
            idle();
            if (tick === 1'b1 && first_tick < 0) first_tick = j;
        end
        n_tests++; if (first_tick != 3) begin n_fail++; $display("FAIL resume_tick: got cycle %0d want 3", first_tick); end
        n_tests++; if (data !== W'(4))  begin n_fail++; $display("FAIL resume_data: got %0d want 4", data); end
        send(C_STOP, 0, 0);
        send(C_STOP, 0, 0);
        n_tests++;
        if ({data, busy, tick, done, wrap, cmd_ready} !== exp_vec() || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_idle: got %h want %h", {data, busy, tick, done, wrap, cmd_ready}, exp_vec());
        end
    endtask

    task automatic test_collision();
        logic [W-1:0] d0;
        send(C_START, 0, 3);
        for (int k = 0; k < 4; k++) idle();
        n_tests++; if (tick !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL coll_ready: tick=%0b ready=%0b want 1/0", tick, cmd_ready);
        end
        d0 = data;
        cyc(0, 1, C_CLEAR, 0, 0);
        n_tests++; if (data !== d0 + W'(1) || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL coll_incr: data=%0d ready=%0b want %0d/1", data, cmd_ready, d0 + W'(1));
        end
        cyc(0, 1, C_CLEAR, 0, 0);
        cmd_valid = 1'b0;
        n_tests++; if (data !== '0) begin n_fail++; $display("FAIL coll_clear: got %0d want 0", data); end
    endtask

    task automatic test_reset_guard();
        bit seen;
        int nt;
        send(C_LOAD, 98, 0);
        send(C_START, 0, 0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            idle();
            seen = (data === W'(100));
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL rg_reach: data=%0d want 100", data); end
        cyc(1, 0, 0, 0, 0);
        rst = 1'b0;
        n_tests++;
        if ({data, busy, tick, done, wrap, cmd_ready} !== {W'(0), 5'b00001}) begin
            n_fail++;
            $display("FAIL rg_reset: got %h want %h", {data, busy, tick, done, wrap, cmd_ready}, {W'(0), 5'b00001});
        end
        send(C_LOAD, 7, 0);
        send(C_START, 4, 1);
        n_tests++; if (data !== '0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rg_guard: data=%0d busy=%0b want 0/1", data, busy);
        end
        nt = 0; seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            idle();
            if (tick === 1'b1) nt++;
            seen = (done === 1'b1);
        end
        n_tests++; if (!seen || nt != 4 || data !== W'(4)) begin
            n_fail++; $display("FAIL rg_done: done=%0b ticks=%0d data=%0d want 1/4/4", done, nt, data);
        end
    endtask

    task automatic test_random();
        int op, arg, dv;
        bit r, v;
        for (int j = 0; j < 600; j++) begin
            r = ($urandom_range(0, 79) == 0);
            v = $urandom_range(0, 1);
            op = $urandom_range(0, 3);
            dv = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       arg = 0;
                1:       arg = $urandom_range(MAXV - 3, MAXV);
                default: arg = $urandom_range(1, 12);
            endcase
            cyc(r, v, op, arg, dv);
            n_tests++;
            if ({data, busy, tick, done, wrap, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model cyc %0d: got %h want %h", j, {data, busy, tick, done, wrap, cmd_ready}, exp_vec());
            end
        end
        cmd_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; cmd_div = '0;
        test_reset();
        test_free_run();
        test_limit();
        test_pause();
        test_collision();
        test_reset_guard();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
